data_proc_ctrl: RTL and testbench
=================================

DATA_PROC_CTRL -- requirements
Module: data_proc_ctrl

Interface
REQ-001 SHALL have clk, input, 1, system clock; all state changes on the rising edge.
REQ-002 SHALL have rstn, input, 1, reset: asynchronous, active-low.
REQ-003 SHALL have mem_valid/mem_ready, input/output, 1/1, CPU bus request and acknowledge.
REQ-004 SHALL have mem_addr/mem_wdata/mem_wstrb, input, 8/32/4, byte address, write data, byte strobes (all-zero strobes mean read).
REQ-005 SHALL have mem_rdata, output, 32, read data, qualified by mem_ready.
REQ-006 SHALL have src_valid/src_ready, input/output, 1/1, pixel stream handshake from the producer.
REQ-007 SHALL have proc_in_valid/proc_in_ready, output/input, 1/1, gated pixel handshake to the processing core.
REQ-008 SHALL have proc_out_valid/proc_out_ready, input/input, 1/1, monitored core output handshake.
REQ-009 SHALL have proc_mode/proc_kernel, output, 2/72, active mode and nine 8-bit coefficients (k0 in [7:0]).
REQ-010 SHALL have irq, output, 1, level interrupt.

Function
REQ-011 Register map: 0x00 MODE[1:0] RW; 0x04 K0..K3, 0x08 K4..K7, 0x0C K8[7:0] RW; 0x10 STATUS RO; 0x14 CTRL; 0x18 FRAME_LEN[19:0] RW; 0x1C IN_CNT RO; 0x20 OUT_CNT RO; 0x24 FRAME_CNT[15:0] RO; other addresses read 0, writes ignored.
REQ-012 Bus: mem_ready SHALL pulse high exactly one cycle, one cycle after mem_valid is sampled high, and SHALL not re-pulse until mem_valid has been low for one cycle.
REQ-013 Writes honour mem_wstrb per byte; reads return zero in unimplemented bits.
REQ-014 CTRL: bit0 START (write-1 pulse, reads 0); bit1 ABORT (write-1 pulse, reads 0); bit2 IRQ_EN RW; bit3 DONE_CLR (write-1 clears STATUS.DONE, reads 0).
REQ-015 STATUS: bit0 BUSY (state not IDLE), bit1 DONE (sticky), bit2 ABORTED (sticky, cleared by START), bit3 LEN_ERR (sticky, cleared by next accepted START), bits[5:4] state code.
REQ-016 FSM states IDLE(0), RUN(1), DRAIN(2), DONE(3).
REQ-017 IDLE->RUN on START with FRAME_LEN!=0: clear IN_CNT/OUT_CNT, copy staged MODE/KERNEL to proc_mode/proc_kernel the same edge.
REQ-018 START with FRAME_LEN==0 SHALL set LEN_ERR and stay IDLE; START outside IDLE SHALL be ignored.
REQ-019 proc_in_valid = src_valid AND state==RUN; src_ready = proc_in_ready AND state==RUN; combinational, no added latency.
REQ-020 IN_CNT increments per src beat in RUN; beat that makes IN_CNT==FRAME_LEN moves RUN->DRAIN.
REQ-021 OUT_CNT increments on every proc_out_valid AND proc_out_ready in RUN or DRAIN.
REQ-022 DRAIN->DONE when OUT_CNT==FRAME_LEN (including the completing beat's edge); DONE->IDLE next cycle, setting DONE and FRAME_CNT+1 (wraps 0xFFFF->0).
REQ-023 ABORT in RUN/DRAIN/DONE SHALL go to IDLE next edge, set ABORTED, counters hold; ABORT in IDLE ignored.
REQ-024 MODE/KERNEL/FRAME_LEN writes while BUSY SHALL update staged registers only; proc_mode/proc_kernel change only at REQ-017.
REQ-025 Simultaneous DONE set and DONE_CLR: set wins.

Reset
REQ-026 On rstn low: state IDLE, all registers, counters, proc_mode, proc_kernel, STATUS, mem_ready, mem_rdata, irq SHALL be 0; src_ready and proc_in_valid 0.
REQ-027 Reset mid-frame SHALL discard the frame without setting any sticky bit.

Configuration
REQ-028 Macro DATA_PROC_CTRL_IRQ_EN defined: irq = IRQ_EN AND (DONE OR ABORTED).
REQ-029 Macro undefined: irq tied 0, CTRL.IRQ_EN reads 0 and ignores writes; all else unchanged.

Verification
REQ-030 FRAME_LEN=16, MODE=1, START, 16 src beats, core 1-cycle latency -> DRAIN then DONE, STATUS=0x02, FRAME_CNT=1, proc_mode=1.
REQ-031 Write MODE=2 during RUN -> proc_mode stays 1 until next START, then 2.
REQ-032 FRAME_LEN=0, START -> STATUS.LEN_ERR=1, BUSY=0, src_ready=0.
REQ-033 ABORT after 5 of 16 beats -> IDLE next cycle, IN_CNT=5, ABORTED=1, irq=1 with IRQ_EN and macro, 0 without.
REQ-034 proc_out_ready held low 10 cycles in DRAIN -> stays DRAIN, src_ready=0; release -> DONE after OUT_CNT reaches 16.
REQ-035 Write 0x04 with wstrb=0x2, wdata=0x0000AB00 -> K1=0xAB, K0/K2/K3 unchanged; mem_ready single-cycle pulse.

Source files
------------

// File: rtl/data_proc_ctrl_if.sv
// Bundle of CPU register bus, pixel stream and processing-core handshakes for data_proc_ctrl.
// slave is the controller side; master is the surrounding system (CPU, producer, core).
interface data_proc_ctrl_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        src_valid;
  logic        src_ready;
  logic        proc_in_valid;
  logic        proc_in_ready;
  logic        proc_out_valid;
  logic        proc_out_ready;
  logic [1:0]  proc_mode;
  logic [71:0] proc_kernel;
  logic        irq;

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    input  src_valid, proc_in_ready, proc_out_valid, proc_out_ready,
    output src_ready, proc_in_valid, proc_mode, proc_kernel, irq
  );

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    output src_valid, proc_in_ready, proc_out_valid, proc_out_ready,
    input  src_ready, proc_in_valid, proc_mode, proc_kernel, irq
  );
endinterface

// File: rtl/data_proc_ctrl.sv
// Frame controller: register file, IDLE/RUN/DRAIN/DONE sequencer gating the pixel stream into the core.
// Bus acks one cycle after request; stream gating is combinational. irq exists only with DATA_PROC_CTRL_IRQ_EN.
module data_proc_ctrl (
  input  logic           clk,
  input  logic           rstn,
  data_proc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_ready;
  logic        r_wait;
  logic [31:0] r_rdata;
  logic [1:0]  r_mode;
  logic [71:0] r_kernel;
  logic [19:0] r_frame_len;
  logic [19:0] r_len_act;
  logic [19:0] r_in_cnt;
  logic [19:0] r_out_cnt;
  logic [15:0] r_frame_cnt;
  logic        r_done;
  logic        r_aborted;
  logic        r_len_err;
  logic [1:0]  r_proc_mode;
  logic [71:0] r_proc_kernel;

  logic        w_acc;
  logic        w_wr;
  logic        w_ctrl_wr;
  logic        w_start;
  logic        w_abort;
  logic        w_done_clr;
  logic        w_irq_en;
  logic        w_in_beat;
  logic        w_out_beat;
  logic [19:0] w_out_next;
  logic [31:0] w_status;
  logic [31:0] w_rd_val;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  // A request is taken only when no ack is in flight and valid has dropped since the last ack.
  assign w_acc      = bus.mem_valid && !r_ready && !r_wait;
  assign w_wr       = w_acc && (bus.mem_wstrb != 4'h0);
  assign w_ctrl_wr  = w_wr && (bus.mem_addr == 8'h14) && bus.mem_wstrb[0];
  assign w_start    = w_ctrl_wr && bus.mem_wdata[0];
  assign w_abort    = w_ctrl_wr && bus.mem_wdata[1];
  assign w_done_clr = w_ctrl_wr && bus.mem_wdata[3];

  assign w_in_beat  = bus.src_valid && bus.proc_in_ready && (r_state == S_RUN);
  assign w_out_beat = bus.proc_out_valid && bus.proc_out_ready &&
                      ((r_state == S_RUN) || (r_state == S_DRAIN));
  assign w_out_next = r_out_cnt + {19'h0, w_out_beat};

  assign w_status = {26'h0, r_state, r_len_err, r_aborted, r_done, (r_state != S_IDLE)};

  always_comb begin
    w_rd_val = '0;
    case (bus.mem_addr)
      8'h00:   w_rd_val[1:0]  = r_mode;
      8'h04:   w_rd_val       = r_kernel[31:0];
      8'h08:   w_rd_val       = r_kernel[63:32];
      8'h0C:   w_rd_val[7:0]  = r_kernel[71:64];
      8'h10:   w_rd_val       = w_status;
      8'h14:   w_rd_val[2]    = w_irq_en;
      8'h18:   w_rd_val[19:0] = r_frame_len;
      8'h1C:   w_rd_val[19:0] = r_in_cnt;
      8'h20:   w_rd_val[19:0] = r_out_cnt;
      8'h24:   w_rd_val[15:0] = r_frame_cnt;
      default: w_rd_val       = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ready     <= 1'b0;
      r_wait      <= 1'b0;
      r_rdata     <= '0;
      r_mode      <= '0;
      r_kernel    <= '0;
      r_frame_len <= '0;
    end else begin
      r_ready <= w_acc;
      r_wait  <= bus.mem_valid && (r_ready || r_wait);
      if (w_acc) r_rdata <= w_wr ? 32'h0 : w_rd_val;
      if (w_wr) begin
        case (bus.mem_addr)
          8'h00: if (bus.mem_wstrb[0]) r_mode <= bus.mem_wdata[1:0];
          8'h04: r_kernel[31:0]  <= f_merge(r_kernel[31:0], bus.mem_wdata, bus.mem_wstrb);
          8'h08: r_kernel[63:32] <= f_merge(r_kernel[63:32], bus.mem_wdata, bus.mem_wstrb);
          8'h0C: if (bus.mem_wstrb[0]) r_kernel[71:64] <= bus.mem_wdata[7:0];
          8'h18: begin
            if (bus.mem_wstrb[0]) r_frame_len[7:0]   <= bus.mem_wdata[7:0];
            if (bus.mem_wstrb[1]) r_frame_len[15:8]  <= bus.mem_wdata[15:8];
            if (bus.mem_wstrb[2]) r_frame_len[19:16] <= bus.mem_wdata[19:16];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_len_act     <= '0;
      r_in_cnt      <= '0;
      r_out_cnt     <= '0;
      r_frame_cnt   <= '0;
      r_done        <= 1'b0;
      r_aborted     <= 1'b0;
      r_len_err     <= 1'b0;
      r_proc_mode   <= '0;
      r_proc_kernel <= '0;
    end else begin
      // The DONE set further down is a later assignment, so it overrides a same-cycle clear.
      if (w_done_clr) r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_start) begin
          r_aborted <= 1'b0;
          if (r_frame_len != 20'h0) begin
            r_state       <= S_RUN;
            r_len_act     <= r_frame_len;
            r_in_cnt      <= '0;
            r_out_cnt     <= '0;
            r_len_err     <= 1'b0;
            r_proc_mode   <= r_mode;
            r_proc_kernel <= r_kernel;
          end else begin
            r_len_err <= 1'b1;
          end
        end
      end else if (w_abort) begin
        r_state   <= S_IDLE;
        r_aborted <= 1'b1;
      end else if (r_state == S_RUN) begin
        r_out_cnt <= w_out_next;
        if (w_in_beat) begin
          r_in_cnt <= r_in_cnt + 20'd1;
          if ((r_in_cnt + 20'd1) == r_len_act) r_state <= S_DRAIN;
        end
      end else if (r_state == S_DRAIN) begin
        r_out_cnt <= w_out_next;
        if (w_out_next == r_len_act) r_state <= S_DONE;
      end else begin
        r_state     <= S_IDLE;
        r_done      <= 1'b1;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

`ifdef DATA_PROC_CTRL_IRQ_EN
  logic r_irq_en;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_irq_en <= 1'b0;
    else if (w_ctrl_wr) r_irq_en <= bus.mem_wdata[2];
  end

  assign w_irq_en = r_irq_en;
  assign bus.irq  = r_irq_en && (r_done || r_aborted);
`else
  assign w_irq_en = 1'b0;
  assign bus.irq  = 1'b0;
`endif

  assign bus.mem_ready     = r_ready;
  assign bus.mem_rdata     = r_rdata;
  assign bus.proc_in_valid = bus.src_valid && (r_state == S_RUN);
  assign bus.src_ready     = bus.proc_in_ready && (r_state == S_RUN);
  assign bus.proc_mode     = r_proc_mode;
  assign bus.proc_kernel   = r_proc_kernel;

endmodule

// File: tb/tb_data_proc_ctrl.sv
// Directed bench for data_proc_ctrl: register bus, frame sequencing, abort, length error, drain stall, reset.
// Core model returns one output per accepted input beat, one cycle later, honouring proc_out_ready.
module tb_data_proc_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  data_proc_ctrl_if bus();

  data_proc_ctrl u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

`ifdef DATA_PROC_CTRL_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
  localparam logic [31:0] CTRL_RB = 32'h4;
`else
  localparam logic IRQ_ON = 1'b0;
  localparam logic [31:0] CTRL_RB = 32'h0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle-latency core; evaluated just after the falling edge so stimulus is settled.
  int   pend = 0;
  logic in_hs_prev = 1'b0;
  logic out_hs_prev = 1'b0;
  initial begin
    bus.proc_out_valid = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rstn) begin
        pend = 0;
        in_hs_prev = 1'b0;
        out_hs_prev = 1'b0;
        bus.proc_out_valid = 1'b0;
      end else begin
        if (out_hs_prev) pend--;
        if (in_hs_prev) pend++;
        in_hs_prev = bus.proc_in_valid && bus.proc_in_ready;
        bus.proc_out_valid = (pend > 0);
        out_hs_prev = bus.proc_out_valid && bus.proc_out_ready;
      end
    end
  end

  task automatic bus_acc(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int hold, output logic [31:0] rd, output int pulses);
    int cyc;
    bit got;
    rd = '0;
    pulses = 0;
    got = 1'b0;
    cyc = 0;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_wstrb = s;
    bus.mem_valid = 1'b1;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_ready) begin
        got = 1'b1;
        rd = bus.mem_rdata;
        pulses++;
      end
    end
    if (!got) chk("bus_timeout", 1'b0, 1'b1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.mem_ready) pulses++;
    end
    bus.mem_valid = 1'b0;
    @(negedge clk);
    if (bus.mem_ready) pulses++;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] rd_dummy;
    int p;
    bus_acc(a, d, 4'hF, 0, rd_dummy, p);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    int p;
    bus_acc(a, 32'h0, 4'h0, 0, d, p);
  endtask

  task automatic send_beats(input int n);
    int sent;
    int cyc;
    sent = 0;
    cyc = 0;
    bus.src_valid = 1'b1;
    while (sent < n && cyc < 200) begin
      if (bus.src_ready) sent++;
      @(negedge clk);
      cyc++;
    end
    bus.src_valid = 1'b0;
    if (sent < n) chk("beat_timeout", sent, n);
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    int tries;
    st = 32'h1;
    tries = 0;
    while (st[0] && tries < 40) begin
      rd(8'h10, st);
      tries++;
    end
    if (st[0]) chk("idle_timeout", st[0], 1'b0);
  endtask

  logic [31:0] v;
  int          pulses;

  initial begin
    bus.mem_valid      = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_wdata      = '0;
    bus.mem_wstrb      = '0;
    bus.src_valid      = 1'b1;
    bus.proc_in_ready  = 1'b1;
    bus.proc_out_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_mem_ready", bus.mem_ready, 1'b0);
    chk("rst_mem_rdata", bus.mem_rdata, 32'h0);
    chk("rst_proc_mode", bus.proc_mode, 2'd0);
    chk("rst_proc_kernel", bus.proc_kernel, 72'h0);
    chk("rst_irq", bus.irq, 1'b0);
    chk("rst_src_ready", bus.src_ready, 1'b0);
    chk("rst_proc_in_valid", bus.proc_in_valid, 1'b0);
    bus.src_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);

    rd(8'h10, v); chk("rst_status", v, 32'h0);
    rd(8'h24, v); chk("rst_frame_cnt", v, 32'h0);

    // Kernel staging and byte-strobe write with a held request.
    wr(8'h04, 32'h04030201);
    wr(8'h08, 32'h08070605);
    wr(8'h0C, 32'hFFFFFF09);
    bus_acc(8'h04, 32'h0000AB00, 4'h2, 3, v, pulses);
    chk("ready_pulses", pulses, 1);
    rd(8'h04, v); chk("k_strobe", v, 32'h0403AB01);
    rd(8'h0C, v); chk("k8_read", v, 32'h00000009);
    rd(8'h28, v); chk("unmapped_read", v, 32'h0);
    chk("kernel_staged_only", bus.proc_kernel, 72'h0);
    wr(8'h18, 32'hFFFFFFFF);
    rd(8'h18, v); chk("frame_len_width", v, 32'h000FFFFF);

    wr(8'h14, 32'h4);
    rd(8'h14, v); chk("ctrl_readback", v, CTRL_RB);
    chk("irq_idle", bus.irq, 1'b0);

    // Frame 1: 16 beats, MODE rewritten mid-frame.
    wr(8'h18, 32'd16);
    wr(8'h00, 32'h1);
    wr(8'h14, 32'h5);
    chk("f1_proc_mode", bus.proc_mode, 2'd1);
    chk("f1_proc_kernel", bus.proc_kernel, 72'h09_08070605_0403AB01);
    send_beats(8);
    wr(8'h00, 32'h2);
    chk("f1_mode_held", bus.proc_mode, 2'd1);
    rd(8'h1C, v); chk("f1_in_cnt_mid", v, 32'd8);
    send_beats(8);
    chk("f1_drain_src_ready", bus.src_ready, 1'b0);
    wait_idle();
    rd(8'h10, v); chk("f1_status", v, 32'h02);
    rd(8'h24, v); chk("f1_frame_cnt", v, 32'd1);
    rd(8'h1C, v); chk("f1_in_cnt", v, 32'd16);
    rd(8'h20, v); chk("f1_out_cnt", v, 32'd16);
    chk("f1_mode_after", bus.proc_mode, 2'd1);
    chk("f1_irq", bus.irq, IRQ_ON);
    wr(8'h14, 32'hC);
    rd(8'h10, v); chk("done_clr_status", v, 32'h0);
    chk("done_clr_irq", bus.irq, 1'b0);

    // Frame 2: new mode picked up at START, aborted after 5 beats.
    wr(8'h14, 32'h5);
    chk("f2_proc_mode", bus.proc_mode, 2'd2);
    send_beats(5);
    wr(8'h14, 32'h6);
    chk("abort_src_ready", bus.src_ready, 1'b0);
    rd(8'h10, v); chk("abort_status", v, 32'h04);
    rd(8'h1C, v); chk("abort_in_cnt", v, 32'd5);
    chk("abort_irq", bus.irq, IRQ_ON);
    repeat (4) @(negedge clk);

    // Zero-length START.
    wr(8'h18, 32'h0);
    wr(8'h14, 32'h5);
    rd(8'h10, v);
    chk("len_err_bit", v[3], 1'b1);
    chk("len_err_busy", v[0], 1'b0);
    chk("len_err_src_ready", bus.src_ready, 1'b0);

    // Frame 3: output side stalled in DRAIN, then released.
    wr(8'h18, 32'd16);
    bus.proc_out_ready = 1'b0;
    wr(8'h14, 32'h5);
    send_beats(16);
    repeat (10) @(negedge clk);
    chk("stall_src_ready", bus.src_ready, 1'b0);
    rd(8'h10, v); chk("stall_status", v, 32'h21);
    rd(8'h20, v); chk("stall_out_cnt", v, 32'd0);
    bus.proc_out_ready = 1'b1;
    wait_idle();
    rd(8'h10, v); chk("f3_status", v, 32'h02);
    rd(8'h20, v); chk("f3_out_cnt", v, 32'd16);
    rd(8'h24, v); chk("f3_frame_cnt", v, 32'd2);

    // Reset in the middle of a frame discards it without sticky bits.
    wr(8'h14, 32'h5);
    send_beats(3);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_src_ready", bus.src_ready, 1'b0);
    rstn = 1'b1;
    @(negedge clk);
    rd(8'h10, v); chk("midrst_status", v, 32'h0);
    rd(8'h24, v); chk("midrst_frame_cnt", v, 32'h0);
    rd(8'h1C, v); chk("midrst_in_cnt", v, 32'h0);
    chk("midrst_proc_mode", bus.proc_mode, 2'd0);
    chk("midrst_irq", bus.irq, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
